guitar_input_conditioner: RTL
=============================

# guitar_input_conditioner

Front-end conditioning stage that sits directly upstream of the processor's Guitar Hero inputs. It synchronizes and debounces the four raw fret-button inputs and the raw strum switch from the controller. It produces the clean `buttons` vector, a single-cycle `strum` pulse with a chord snapshot, and the periodic `gameclk` tick that the processor consumes.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable synchronized samples required before a debounced output changes. Legal range is ≥1.
- `GAMECLK_DIV`, default 833333: clock cycles per `gameclk` tick (60 Hz at 50 MHz). Legal range is ≥2.

Ports:
- `clock` in 1: single system clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low. Low clears all state immediately.
- `btn_raw` in 4: raw, asynchronous, bouncy fret buttons; bit i = fret i.
- `strum_raw` in 1: raw, asynchronous, bouncy strum switch; 1 = strummed.
- `game_en` in 1: synchronous to `clock`; enables the `gameclk` divider.
- `buttons` out 4: debounced fret state.
- `strum` out 1: one-cycle pulse on each debounced strum rising edge.
- `chord` out 4: value of `buttons` captured on the edge that asserts `strum`; held until the next strum.
- `gameclk` out 1: one-cycle tick every `GAMECLK_DIV` cycles while `game_en` is high.

## Operation
Input path (per channel, five channels: 4 frets plus strum):
- Two-flop synchronizer `s1 -> s2`.
- Each channel has a `stable` register and a counter of width `$clog2(DEBOUNCE_CYCLES)`, minimum 1.
- Each edge:
  - If `s2 == stable`: counter clears to 0.
  - Else, if counter == `DEBOUNCE_CYCLES-1`: `stable <= s2` and counter clears to 0.
  - Else: counter increments.
- Any single-cycle return of `s2` to `stable` restarts the count. This rejects bounce.
- `buttons` = fret `stable` bits.

Strum path:
- Registered rising-edge detect on strum `stable`.
- `strum` is high for exactly one cycle, starting the edge after strum `stable` goes 0→1.
- On that same edge, `chord <= buttons` (current debounced value).
- A held strum produces no further pulses. Release (debounced 1→0) produces no pulse.

Game clock:
- Counter of width `$clog2(GAMECLK_DIV)`.
- While `game_en` = 1: counter increments each edge. When counter == `GAMECLK_DIV-1`, `gameclk <= 1` and counter clears to 0. Otherwise `gameclk <= 0`.
- While `game_en` = 0: counter is held at 0 and `gameclk <= 0`. Re-enable starts a full period.

## Timing
- Reset values: `buttons`=0, `strum`=0, `chord`=0, `gameclk`=0. All synchronizer flops, `stable` registers and counters are 0.
- Reset takes effect asynchronously, mid-cycle. Release is sampled on the next rising edge.
- Debounce latency:
  - Raw input changes before edge 1 and stays stable.
  - `s2` updates at edge 2.
  - `stable`/`buttons` update at edge 2+`DEBOUNCE_CYCLES`.
- Strum latency: `strum` and `chord` update at edge 3+`DEBOUNCE_CYCLES`.
- Simultaneous fret and strum raw changes: both debounce on the same edge. `chord` therefore captures the new fret value.
- Reset mid-debounce: partial counts are discarded. Inputs held through reset re-debounce with full latency after release. No spurious `strum` is produced for a strum already low at release. A strum held high through reset produces exactly one pulse after the full re-debounce.
- `gameclk` period: with `game_en` high before edge 1, ticks at edges `GAMECLK_DIV`, 2·`GAMECLK_DIV`, and so on. The period is exact; no drift.
- No wrap-around exposure: every counter clears at its terminal value.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `GAMECLK_DIV`=10.
- Clean press: `btn_raw` 0000→0001 before edge 1, held. `buttons`=0000 through edge 5; `buttons`=0001 after edge 6. Release mirrors this: back to 0000 six edges after release.
- Bounce rejection: toggle `btn_raw[1]` every 3 cycles for 24 cycles, then hold high. `buttons[1]` stays 0 throughout the bounce. It rises exactly 6 edges after the final transition.
- Strum with chord: `btn_raw`=0101 settled, `strum_raw` rises and is held 30 cycles. `strum` is high only after edge 7, with `chord`=0101. No further pulse while held. Release, then re-strum with `btn_raw`=1000 settled: a second single pulse with `chord`=1000.
- Game clock: `game_en`=1 for 35 cycles. Exactly 3 one-cycle `gameclk` pulses, after edges 10, 20 and 30. Drop `game_en` at cycle 25 and re-raise at 40: no pulse at edge 30; next pulse at edge 50.
- Async reset mid-operation: `btn_raw`=1111 held. Assert `reset` low between edges 4 and 5, with counters partially advanced. All outputs read 0 immediately, before the next edge. Release before edge 8: `buttons`=1111 only after edge 13 (full 6-edge latency from the first post-release edge, edge 8).
- Simultaneous change: `btn_raw` 0000→0110 and `strum_raw` 0→1 before the same edge 1. `buttons`=0110 after edge 6. `strum` pulses after edge 7 with `chord`=0110.

Source files
------------

// File: rtl/guitar_input_conditioner_if.sv
// Bundle between the controller front end and the guitar input conditioner.
//   btn_raw   : raw, asynchronous fret buttons (bit i = fret i)
//   strum_raw : raw, asynchronous strum switch (1 = strummed)
//   game_en   : synchronous enable for the game clock divider
//   buttons   : debounced fret state
//   strum     : one-cycle pulse per debounced strum press
//   chord     : fret state captured with the last strum pulse
//   gameclk   : one-cycle periodic game tick
// master drives the raw inputs and consumes the conditioned outputs;
// slave is the conditioner itself.
interface guitar_input_conditioner_if;
    logic [3:0] btn_raw;
    logic       strum_raw;
    logic       game_en;
    logic [3:0] buttons;
    logic       strum;
    logic [3:0] chord;
    logic       gameclk;

    modport master (
        output btn_raw,
        output strum_raw,
        output game_en,
        input  buttons,
        input  strum,
        input  chord,
        input  gameclk
    );

    modport slave (
        input  btn_raw,
        input  strum_raw,
        input  game_en,
        output buttons,
        output strum,
        output chord,
        output gameclk
    );
endinterface

// File: rtl/guitar_input_conditioner.sv
// Guitar input conditioner: synchronizes and debounces four fret buttons and
// the strum switch, emits a one-cycle strum pulse with a chord snapshot, and
// divides the system clock down to the periodic game tick.
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous, active-low; clears all state
//   gic   : slave side of guitar_input_conditioner_if (raw inputs in,
//           buttons/strum/chord/gameclk out, all registered)
module guitar_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned GAMECLK_DIV     = 833333
) (
    input logic                        clock,
    input logic                        reset,
    guitar_input_conditioner_if.slave  gic
);

    // Channels 0..3 are frets, channel 4 is strum.
    localparam int unsigned NUM_FRETS = 4;
    localparam int unsigned NUM_CH    = NUM_FRETS + 1;
    localparam int unsigned STRUM_CH  = NUM_FRETS;

    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned GC_W = (GAMECLK_DIV > 2) ? $clog2(GAMECLK_DIV) : 1;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [GC_W-1:0] GC_LAST = GC_W'(GAMECLK_DIV - 1);

    logic [NUM_CH-1:0]            raw_c;
    logic [NUM_CH-1:0]            sync1_q;
    logic [NUM_CH-1:0]            sync2_q;
    logic [NUM_CH-1:0]            stable_q;
    logic [NUM_CH-1:0]            stable_d;
    logic [NUM_CH-1:0][DB_W-1:0]  db_cnt_q;
    logic [NUM_CH-1:0][DB_W-1:0]  db_cnt_d;

    logic                         strum_prev_q;
    logic                         strum_q;
    logic [NUM_FRETS-1:0]         chord_q;
    logic                         strum_rise_c;

    logic [GC_W-1:0]              gc_cnt_q;
    logic [GC_W-1:0]              gc_cnt_d;
    logic                         gameclk_q;
    logic                         gameclk_d;

    assign raw_c = {gic.strum_raw, gic.btn_raw};

    // Two-flop synchronizer for every raw channel.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_c;
            sync2_q <= sync1_q;
        end
    end

    // Debounce next state: a channel must disagree with its stable value for
    // DEBOUNCE_CYCLES consecutive samples before it is accepted; any sample
    // that agrees again restarts the count.
    always_comb begin
        stable_d = stable_q;
        db_cnt_d = db_cnt_q;
        for (int ch = 0; ch < int'(NUM_CH); ch++) begin
            if (sync2_q[ch] == stable_q[ch]) begin
                db_cnt_d[ch] = '0;
            end else if (db_cnt_q[ch] == DB_LAST) begin
                stable_d[ch] = sync2_q[ch];
                db_cnt_d[ch] = '0;
            end else begin
                db_cnt_d[ch] = db_cnt_q[ch] + DB_W'(1);
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stable_q <= '0;
            db_cnt_q <= '0;
        end else begin
            stable_q <= stable_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    // Rising edge of the debounced strum, seen against its value one edge ago.
    assign strum_rise_c = stable_q[STRUM_CH] & ~strum_prev_q;

    // Strum pulse and chord snapshot; chord holds until the next press.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            strum_prev_q <= 1'b0;
            strum_q      <= 1'b0;
            chord_q      <= '0;
        end else begin
            strum_prev_q <= stable_q[STRUM_CH];
            strum_q      <= strum_rise_c;
            if (strum_rise_c) begin
                chord_q <= stable_q[NUM_FRETS-1:0];
            end
        end
    end

    // Game clock divider next state; disabling parks the counter so that
    // re-enabling always yields a full period before the first tick.
    always_comb begin
        gc_cnt_d  = gc_cnt_q;
        gameclk_d = 1'b0;
        if (!gic.game_en) begin
            gc_cnt_d = '0;
        end else if (gc_cnt_q == GC_LAST) begin
            gc_cnt_d  = '0;
            gameclk_d = 1'b1;
        end else begin
            gc_cnt_d = gc_cnt_q + GC_W'(1);
        end
    end

    // Game clock registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            gc_cnt_q  <= '0;
            gameclk_q <= 1'b0;
        end else begin
            gc_cnt_q  <= gc_cnt_d;
            gameclk_q <= gameclk_d;
        end
    end

    assign gic.buttons = stable_q[NUM_FRETS-1:0];
    assign gic.strum   = strum_q;
    assign gic.chord   = chord_q;
    assign gic.gameclk = gameclk_q;

endmodule
